// File: rtl/toggle_activity_monitor.sv
// Windowed switching-activity and signal-probability monitor for a 1-bit net.
// Counts 0<->1 transitions and 1-samples over win_len valid samples, start/done handshake.
module toggle_activity_monitor #(
    parameter int WIN_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    input  logic             abort,
    input  logic             n_7,
    input  logic             sample_valid,
    output logic             busy,
    output logic             done,
    output logic             result_valid,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic [CNT_W-1:0] ones_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FIRST = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    localparam logic [WIN_W-1:0] WIN_ZERO = {WIN_W{1'b0}};
    localparam logic [WIN_W-1:0] WIN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                 input logic             inc);
        logic [CNT_W-1:0] result;
        if (inc && (value != CNT_MAX)) begin
            result = value + CNT_ONE;
        end else begin
            result = value;
        end
        return result;
    endfunction

    logic [1:0]       state_r;
    logic [WIN_W-1:0] win_len_r;
    logic [WIN_W-1:0] remaining_r;
    logic             prev_r;
    logic [CNT_W-1:0] toggle_cnt_r;
    logic [CNT_W-1:0] ones_cnt_r;
    logic             done_r;
    logic             result_valid_r;
    logic             busy_r;

    logic [1:0]       state_nxt_s;
    logic [WIN_W-1:0] win_len_nxt_s;
    logic [WIN_W-1:0] remaining_nxt_s;
    logic             prev_nxt_s;
    logic [CNT_W-1:0] toggle_nxt_s;
    logic [CNT_W-1:0] ones_nxt_s;
    logic             enter_hold_s;

    // Next-state and datapath update; abort overrides everything including start.
    always_comb begin
        state_nxt_s     = state_r;
        win_len_nxt_s   = win_len_r;
        remaining_nxt_s = remaining_r;
        prev_nxt_s      = prev_r;
        toggle_nxt_s    = toggle_cnt_r;
        ones_nxt_s      = ones_cnt_r;
        enter_hold_s    = 1'b0;

        if (abort) begin
            state_nxt_s     = IDLE;
            remaining_nxt_s = WIN_ZERO;
            prev_nxt_s      = 1'b0;
            toggle_nxt_s    = CNT_ZERO;
            ones_nxt_s      = CNT_ZERO;
        end else begin
            case (state_r)
                IDLE, HOLD: begin
                    if (start) begin
                        win_len_nxt_s = win_len;
                        toggle_nxt_s  = CNT_ZERO;
                        ones_nxt_s    = CNT_ZERO;
                        if (win_len == WIN_ZERO) begin
                            state_nxt_s  = HOLD;
                            enter_hold_s = 1'b1;
                        end else begin
                            state_nxt_s = FIRST;
                        end
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                FIRST: begin
                    if (sample_valid) begin
                        prev_nxt_s      = n_7;
                        ones_nxt_s      = sat_inc(ones_cnt_r, n_7);
                        remaining_nxt_s = win_len_r - WIN_ONE;
                        if (win_len_r == WIN_ONE) begin
                            state_nxt_s  = HOLD;
                            enter_hold_s = 1'b1;
                        end else begin
                            state_nxt_s = RUN;
                        end
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                RUN: begin
                    if (sample_valid) begin
                        prev_nxt_s      = n_7;
                        toggle_nxt_s    = sat_inc(toggle_cnt_r, n_7 ^ prev_r);
                        ones_nxt_s      = sat_inc(ones_cnt_r, n_7);
                        remaining_nxt_s = remaining_r - WIN_ONE;
                        if (remaining_r == WIN_ONE) begin
                            state_nxt_s  = HOLD;
                            enter_hold_s = 1'b1;
                        end else begin
                            state_nxt_s = RUN;
                        end
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                default: begin
                    state_nxt_s     = IDLE;
                    remaining_nxt_s = WIN_ZERO;
                    toggle_nxt_s    = CNT_ZERO;
                    ones_nxt_s      = CNT_ZERO;
                end
            endcase
        end
    end

    // State, counters and status flags; flags derive from the next state so outputs stay registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            win_len_r      <= WIN_ZERO;
            remaining_r    <= WIN_ZERO;
            prev_r         <= 1'b0;
            toggle_cnt_r   <= CNT_ZERO;
            ones_cnt_r     <= CNT_ZERO;
            done_r         <= 1'b0;
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            win_len_r      <= win_len_nxt_s;
            remaining_r    <= remaining_nxt_s;
            prev_r         <= prev_nxt_s;
            toggle_cnt_r   <= toggle_nxt_s;
            ones_cnt_r     <= ones_nxt_s;
            done_r         <= enter_hold_s;
            result_valid_r <= (state_nxt_s == HOLD);
            busy_r         <= (state_nxt_s == FIRST) || (state_nxt_s == RUN);
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign result_valid = result_valid_r;
    assign toggle_cnt   = toggle_cnt_r;
    assign ones_cnt     = ones_cnt_r;

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Directed bench for toggle_activity_monitor: window counts, gaps, saturation, start/abort/reset.
module tb_toggle_activity_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] win_len;
    logic        abort;
    logic        n_7;
    logic        sample_valid;
    logic        busy;
    logic        done;
    logic        result_valid;
    logic [15:0] toggle_cnt;
    logic [15:0] ones_cnt;

    logic        s_start;
    logic [15:0] s_win_len;
    logic        s_n_7;
    logic        s_valid;
    logic        s_busy;
    logic        s_done;
    logic        s_result_valid;
    logic [3:0]  s_toggle_cnt;
    logic [3:0]  s_ones_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    toggle_activity_monitor #(.WIN_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len), .abort(abort),
        .n_7(n_7), .sample_valid(sample_valid), .busy(busy), .done(done),
        .result_valid(result_valid), .toggle_cnt(toggle_cnt), .ones_cnt(ones_cnt)
    );

    toggle_activity_monitor #(.WIN_W(16), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(s_start), .win_len(s_win_len), .abort(abort),
        .n_7(s_n_7), .sample_valid(s_valid), .busy(s_busy), .done(s_done),
        .result_valid(s_result_valid), .toggle_cnt(s_toggle_cnt), .ones_cnt(s_ones_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        total++;
        if ({busy, done, result_valid, toggle_cnt, ones_cnt} !== 35'd0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%0b done=%0b rv=%0b tog=%0d ones=%0d want all 0",
                     busy, done, result_valid, toggle_cnt, ones_cnt);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] seq;
        seq = 8'b0011_1010; // bit k is sample k: 0,1,0,1,1,1,0,0
        start = 1'b1; win_len = 16'd8;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL basic_busy: got %0b want 1", busy);
        end
        for (int k = 0; k < 8; k++) begin
            n_7 = seq[k]; sample_valid = 1'b1;
            tick();
            if (k < 7) begin
                total++;
                if (done !== 1'b0) begin
                    bad++; $display("FAIL basic_early_done: sample %0d got %0b want 0", k, done);
                end
            end
        end
        sample_valid = 1'b0; n_7 = 1'b0;
        total++;
        if ({done, result_valid, busy} !== 3'b110) begin
            bad++; $display("FAIL basic_flags: got done=%0b rv=%0b busy=%0b want 1 1 0",
                            done, result_valid, busy);
        end
        total++;
        if (toggle_cnt !== 16'd4 || ones_cnt !== 16'd4) begin
            bad++; $display("FAIL basic_counts: got tog=%0d ones=%0d want 4 4", toggle_cnt, ones_cnt);
        end
        n_7 = 1'b1; sample_valid = 1'b1;
        tick();
        n_7 = 1'b0;
        tick();
        sample_valid = 1'b0;
        total++;
        if ({done, result_valid} !== 2'b01 || toggle_cnt !== 16'd4 || ones_cnt !== 16'd4) begin
            bad++; $display("FAIL basic_hold: got done=%0b rv=%0b tog=%0d ones=%0d want 0 1 4 4",
                            done, result_valid, toggle_cnt, ones_cnt);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] seq;
        int         cycles;
        seq = 8'b0011_1010;
        cycles = 0;
        start = 1'b1; win_len = 16'd8;
        tick();
        start = 1'b0;
        total++;
        if (result_valid !== 1'b0) begin
            bad++; $display("FAIL gaps_rv_drop: got %0b want 0", result_valid);
        end
        for (int k = 0; k < 8; k++) begin
            n_7 = seq[k]; sample_valid = 1'b1;
            tick(); cycles++;
            if (k < 7) begin
                n_7 = 1'b1; sample_valid = 1'b0;
                tick(); cycles++;
                total++;
                if (done !== 1'b0) begin
                    bad++; $display("FAIL gaps_early_done: cycle %0d got %0b want 0", cycles, done);
                end
            end
        end
        sample_valid = 1'b0; n_7 = 1'b0;
        total++;
        if (done !== 1'b1 || cycles != 15) begin
            bad++; $display("FAIL gaps_done: got done=%0b after %0d cycles want 1 after 15", done, cycles);
        end
        total++;
        if (toggle_cnt !== 16'd4 || ones_cnt !== 16'd4) begin
            bad++; $display("FAIL gaps_counts: got tog=%0d ones=%0d want 4 4", toggle_cnt, ones_cnt);
        end
    endtask

    task automatic test_saturation();
        s_start = 1'b1; s_win_len = 16'd20;
        tick();
        s_start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            s_n_7 = (k % 2 == 0); s_valid = 1'b1;
            tick();
        end
        s_valid = 1'b0;
        total++;
        if (s_done !== 1'b1 || s_toggle_cnt !== 4'd15 || s_ones_cnt !== 4'd10) begin
            bad++; $display("FAIL sat_counts: got done=%0b tog=%0d ones=%0d want 1 15 10",
                            s_done, s_toggle_cnt, s_ones_cnt);
        end
    endtask

    task automatic test_zero_len();
        start = 1'b1; win_len = 16'd0;
        tick();
        start = 1'b0;
        total++;
        if ({done, result_valid, busy} !== 3'b110 || toggle_cnt !== 16'd0 || ones_cnt !== 16'd0) begin
            bad++; $display("FAIL zero_len: got done=%0b rv=%0b busy=%0b tog=%0d ones=%0d want 1 1 0 0 0",
                            done, result_valid, busy, toggle_cnt, ones_cnt);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL zero_len_pulse: got done=%0b busy=%0b want 0 0", done, busy);
        end
        start = 1'b1; win_len = 16'd1;
        tick();
        start = 1'b0;
        n_7 = 1'b1; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0; n_7 = 1'b0;
        total++;
        if (done !== 1'b1 || toggle_cnt !== 16'd0 || ones_cnt !== 16'd1) begin
            bad++; $display("FAIL len_one: got done=%0b tog=%0d ones=%0d want 1 0 1",
                            done, toggle_cnt, ones_cnt);
        end
    endtask

    task automatic test_start_while_busy();
        logic [3:0] seq;
        seq = 4'b1011; // samples 1,1,0,1 -> 2 toggles, 3 ones
        start = 1'b1; win_len = 16'd4;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_7 = seq[k]; sample_valid = 1'b1;
            start = (k == 1); win_len = (k == 1) ? 16'd2 : 16'd4;
            tick();
            if (k < 3) begin
                total++;
                if (done !== 1'b0 || busy !== 1'b1) begin
                    bad++; $display("FAIL busy_start_early: sample %0d got done=%0b busy=%0b want 0 1",
                                    k, done, busy);
                end
            end
        end
        start = 1'b0; sample_valid = 1'b0;
        total++;
        if (done !== 1'b1 || toggle_cnt !== 16'd2 || ones_cnt !== 16'd3) begin
            bad++; $display("FAIL busy_start_counts: got done=%0b tog=%0d ones=%0d want 1 2 3",
                            done, toggle_cnt, ones_cnt);
        end
    endtask

    task automatic test_abort();
        start = 1'b1; win_len = 16'd8;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_7 = 1'b1; sample_valid = 1'b1;
            tick();
        end
        abort = 1'b1; sample_valid = 1'b0;
        tick();
        abort = 1'b0;
        total++;
        if ({busy, done, result_valid} !== 3'b000 || toggle_cnt !== 16'd0 || ones_cnt !== 16'd0) begin
            bad++; $display("FAIL abort_clear: got busy=%0b done=%0b rv=%0b tog=%0d ones=%0d want all 0",
                            busy, done, result_valid, toggle_cnt, ones_cnt);
        end
        abort = 1'b1; start = 1'b1; win_len = 16'd4;
        tick();
        abort = 1'b0; start = 1'b0;
        total++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            bad++; $display("FAIL abort_wins: got busy=%0b rv=%0b want 0 0", busy, result_valid);
        end
    endtask

    task automatic test_reset_mid_window();
        int done_seen;
        done_seen = 0;
        start = 1'b1; win_len = 16'd3;
        tick();
        start = 1'b0;
        n_7 = 1'b1; sample_valid = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || ones_cnt !== 16'd0) begin
            bad++; $display("FAIL rst_async: got busy=%0b ones=%0d want 0 0", busy, ones_cnt);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) done_seen++;
        end
        sample_valid = 1'b0; n_7 = 1'b0;
        total++;
        if (done_seen != 0) begin
            bad++; $display("FAIL rst_no_done: got %0d active cycles want 0", done_seen);
        end
    endtask

    task automatic test_upstream();
        logic n_1, n_2, n_3, n_4, f, prev_f;
        int   exp_tog, exp_ones;
        exp_tog = 0; exp_ones = 0; prev_f = 1'b0;
        start = 1'b1; win_len = 16'd16;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_1 = i[0]; n_2 = i[1]; n_3 = i[2]; n_4 = i[3];
            f = n_1 ^ n_2 ^ (n_3 & n_4);
            if (f) exp_ones++;
            if (i > 0 && (f ^ prev_f)) exp_tog++;
            prev_f = f;
            n_7 = f; sample_valid = 1'b1;
            tick();
        end
        sample_valid = 1'b0;
        total++;
        if (done !== 1'b1 || ones_cnt !== 16'(exp_ones) || exp_ones != 8) begin
            bad++; $display("FAIL upstream_ones: got done=%0b ones=%0d want 1 8", done, ones_cnt);
        end
        total++;
        if (toggle_cnt !== 16'(exp_tog)) begin
            bad++; $display("FAIL upstream_toggles: got %0d want %0d", toggle_cnt, exp_tog);
        end
    endtask

    initial begin
        start = 1'b0; win_len = 16'd0; abort = 1'b0; n_7 = 1'b0; sample_valid = 1'b0;
        s_start = 1'b0; s_win_len = 16'd0; s_n_7 = 1'b0; s_valid = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_saturation();
        test_zero_len();
        test_start_while_busy();
        test_abort();
        test_reset_mid_window();
        test_upstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
